// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: mem_op codes,
// funct3 size encodings, FSM states and a size decode helper.
package mem_pkg;

  localparam logic [1:0] MOP_NONE  = 2'b00;
  localparam logic [1:0] MOP_LOAD  = 2'b01;
  localparam logic [1:0] MOP_STORE = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_t;

  // Unused funct3 codes fall through to a word access.
  function automatic size_t size_of(input logic [2:0] f3);
    size_t s;
    case (f3)
      F3_B, F3_BU: s = SZ_B;
      F3_H, F3_HU: s = SZ_H;
      default:     s = SZ_W;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data memory bus between the access unit (master) and memory (slave).
// Ports: req/we/addr/wdata/be from master; ack/rdata from slave.
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr,
    output dmem_wdata, dmem_be,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr,
    input  dmem_wdata, dmem_be,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/load_align.sv
// Load lane extract and sign/zero extend.
// Ports: rdata word, addr[1:0], funct3 in; aligned data out.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;

  always_comb begin
    b    = rdata[{addr, 3'b000} +: 8];
    h    = addr[1] ? rdata[31:16] : rdata[15:0];
    sx   = ~funct3[2];
    data = rdata;
    case (size_of(funct3))
      SZ_B:    data = {{24{sx & b[7]}}, b};
      SZ_H:    data = {{16{sx & h[15]}}, h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: IDLE/MEM/RESP FSM between execute and dmem.
// Ports: clk, rst_n, ex_* op in, dmem bus (master), wb_*, misalign_trap.
// Build option: MISALIGN_TRAP_EN traps misaligned half/word accesses.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] store_data,
  input  logic [1:0]  mem_op,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd_in,
  mem_access_unit_if.master dmem,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        misalign_trap
);

  state_t      state, nxt;
  logic        ld_q, st_q;
  logic [31:0] addr_q, wdata_q, res_q;
  logic [3:0]  be_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic [31:0] ld_data;

  logic        is_ld, is_st, is_mem, trap;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  size_t       sz;

  always_comb begin
    is_ld  = mem_op == MOP_LOAD;
    is_st  = mem_op == MOP_STORE;
    is_mem = is_ld | is_st;
    sz     = size_of(funct3);
`ifdef MISALIGN_TRAP_EN
    trap = is_mem &
           ((sz == SZ_H && ALU_result[0]) ||
            (sz == SZ_W && ALU_result[1:0] != 2'b00));
`else
    trap = 1'b0;
`endif
    be_n = 4'b1111;
    wd_n = store_data;
    case (sz)
      SZ_B: begin
        be_n = 4'b0001 << ALU_result[1:0];
        wd_n = {4{store_data[7:0]}};
      end
      SZ_H: begin
        be_n = ALU_result[1] ? 4'b1100 : 4'b0011;
        wd_n = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:
        if (ex_valid)
          nxt = (is_mem && !trap) ? S_MEM : S_RESP;
      S_MEM:
        if (dmem.dmem_ack) nxt = S_RESP;
      S_RESP:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  load_align u_align (
    .rdata  (dmem.dmem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .data   (ld_data)
  );

`ifdef MISALIGN_TRAP_EN
  logic trap_q;

  always_ff @(posedge clk) begin
    if (!rst_n)
      trap_q <= 1'b0;
    else if (state == S_IDLE && ex_valid)
      trap_q <= trap;
  end

  assign misalign_trap = (state == S_RESP) & trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      res_q   <= '0;
    end else if (state == S_IDLE && ex_valid) begin
      ld_q    <= is_ld & ~trap;
      st_q    <= is_st & ~trap;
      addr_q  <= ALU_result;
      wdata_q <= wd_n;
      be_q    <= be_n;
      f3_q    <= funct3;
      rd_q    <= (is_st | trap) ? 5'd0 : rd_in;
      res_q   <= is_mem ? 32'd0 : ALU_result;
    end else if (state == S_MEM && dmem.dmem_ack) begin
      res_q   <= ld_q ? ld_data : 32'd0;
    end
  end

  assign ex_ready        = state == S_IDLE;
  assign dmem.dmem_req   = state == S_MEM;
  assign dmem.dmem_we    = (state == S_MEM) & st_q;
  assign dmem.dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_be    = be_q;
  assign wb_valid        = state == S_RESP;
  assign wb_data         = wb_valid ? res_q : 32'd0;
  assign wb_rd           = wb_valid ? rd_q : 5'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed ops, memory
// responder with wait states, writeback monitor with latency check.
module tb_mem_access_unit;
  import mem_pkg::*;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    logic [4:0]  rd;
    bit          trap;
    int          lat;
    int          acc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    bit          we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
    bit          abandon;
  } dm_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        ex_valid = 0;
  logic        ex_ready;
  logic [31:0] alu = 0;
  logic [31:0] sdata = 0;
  logic [1:0]  mop = 0;
  logic [2:0]  f3 = 0;
  logic [4:0]  rd = 0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign_trap;
  logic        ack_r = 0;
  logic        stray = 0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  wb_t wbq[$];
  dm_t dmq[$];

  mem_access_unit_if bus ();
  assign bus.dmem_ack = ack_r | stray;

  mem_access_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ALU_result    (alu),
    .store_data    (sdata),
    .mem_op        (mop),
    .funct3        (f3),
    .rd_in         (rd),
    .dmem          (bus.master),
    .wb_valid      (wb_valid),
    .wb_data       (wb_data),
    .wb_rd         (wb_rd),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  function automatic wb_t mkwb(input logic [31:0] d, input bit c,
                               input logic [4:0] r, input bit t,
                               input int l);
    wb_t e;
    e.data = d; e.chk_data = c; e.rd = r;
    e.trap = t; e.lat = l; e.acc = 0;
    return e;
  endfunction

  // Writeback monitor
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_wb: got wb_valid=1 want 0");
        end else begin
          e = wbq.pop_front();
          chk("wb_rd", 32'(wb_rd), 32'(e.rd));
          if (e.chk_data) chk("wb_data", wb_data, e.data);
          chk("misalign_trap", 32'(misalign_trap), 32'(e.trap));
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  // Memory responder
  initial begin
    dm_t d;
    bit  act;
    int  cnt;
    act = 0; cnt = 0;
    d = '{32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 0};
    bus.dmem_rdata = 32'hDEAD_DEAD;
    forever begin
      @(negedge clk);
      if (bus.dmem_req) begin
        if (!act) begin
          if (dmq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req: got dmem_req=1 want 0");
            d = '{32'h0, 0, 4'h0, 32'h0, 32'h0, 0, 1};
          end else begin
            d = dmq.pop_front();
          end
          act = 1; cnt = 0;
        end
        chk("dmem_addr", bus.dmem_addr, d.addr);
        chk("dmem_we", 32'(bus.dmem_we), 32'(d.we));
        if (d.we) begin
          chk("dmem_be", 32'(bus.dmem_be), 32'(d.be));
          chk("dmem_wdata", bus.dmem_wdata, d.wdata);
        end
        ack_r = (cnt == d.wait_n);
        bus.dmem_rdata = ack_r ? d.rdata : 32'hDEAD_DEAD;
        cnt++;
      end else begin
        if (act) begin
          act = 0;
          if (!d.abandon)
            chk("req_cycles", 32'(cnt), 32'(d.wait_n + 1));
        end
        ack_r = 0;
        bus.dmem_rdata = 32'hDEAD_DEAD;
      end
    end
  end

  task automatic issue(input logic [1:0] m, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic [4:0] r, input bit push,
                       input wb_t e);
    int n;
    n = 0;
    @(negedge clk);
    while (!ex_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ex_ready", 32'(ex_ready), 32'd1);
    mop = m; f3 = fn; alu = a; sdata = sd; rd = r;
    ex_valid = 1;
    @(posedge clk);
    #1;
    ex_valid = 0; mop = MOP_NONE;
    e.acc = cyc;
    if (push) wbq.push_back(e);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!(ex_ready && wbq.size() == 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("op_done", 32'(ex_ready && wbq.size() == 0), 32'd1);
  endtask

  task automatic ld(input logic [2:0] fn, input logic [31:0] a,
                    input logic [31:0] rdat, input int w,
                    input logic [31:0] exp, input logic [4:0] r);
    dmq.push_back('{a & ~32'h3, 0, 4'h0, 32'h0, rdat, w, 0});
    issue(MOP_LOAD, fn, a, 32'h0, r, 1, mkwb(exp, 1, r, 0, w + 2));
    wait_done();
  endtask

  task automatic st(input logic [2:0] fn, input logic [31:0] a,
                    input logic [31:0] sd, input logic [3:0] be,
                    input logic [31:0] wd, input int w);
    dmq.push_back('{a & ~32'h3, 1, be, wd, 32'h0, w, 0});
    issue(MOP_STORE, fn, a, sd, 5'd9, 1, mkwb(0, 0, 0, 0, w + 2));
    wait_done();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ex_ready", 32'(ex_ready), 32'd1);
    chk("rst_req", 32'(bus.dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    rst_n = 1;

    issue(MOP_NONE, 3'b000, 32'h0000_1234, 0, 5'd5, 1,
          mkwb(32'h1234, 1, 5'd5, 0, 1));
    wait_done();
    ld(F3_B, 32'h103, 32'h80FF_0000, 3, 32'hFFFF_FF80, 5'd7);
    st(F3_H, 32'h202, 32'hABCD_1234, 4'b1100, 32'h1234_1234, 0);
    ld(F3_HU, 32'h2, 32'h8001_0000, 0, 32'h0000_8001, 5'd3);
    ld(F3_H, 32'h100, 32'h0000_8001, 1, 32'hFFFF_8001, 5'd4);
    ld(F3_BU, 32'h101, 32'h0000_9A00, 0, 32'h0000_009A, 5'd6);
    ld(F3_B, 32'h0, 32'h0000_007F, 2, 32'h0000_007F, 5'd8);
    st(F3_B, 32'h13, 32'h0000_0055, 4'b1000, 32'h5555_5555, 0);
    st(F3_W, 32'h20, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1);
    ld(3'b111, 32'h40, 32'h1234_5678, 0, 32'h1234_5678, 5'd10);
    issue(2'b11, 3'b010, 32'hFFFF_0000, 0, 5'd31, 1,
          mkwb(32'hFFFF_0000, 1, 5'd31, 0, 1));
    wait_done();

`ifdef MISALIGN_TRAP_EN
    issue(MOP_LOAD, F3_W, 32'h3, 0, 5'd12, 1, mkwb(0, 0, 0, 1, 1));
    wait_done();
`else
    ld(F3_W, 32'h3, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 5'd12);
`endif

    // Reset while a load waits in MEM, then a stray ack
    dmq.push_back('{32'h300, 0, 4'h0, 32'h0, 32'h1111, 20, 1});
    issue(MOP_LOAD, F3_B, 32'h300, 0, 5'd2, 0, mkwb(0, 0, 0, 0, 0));
    @(negedge clk);
    chk("mid_mem_req", 32'(bus.dmem_req), 32'd1);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("abort_ex_ready", 32'(ex_ready), 32'd1);
    chk("abort_req", 32'(bus.dmem_req), 32'd0);
    chk("abort_wb_valid", 32'(wb_valid), 32'd0);
    stray = 1;
    @(negedge clk);
    stray = 0;
    repeat (3) @(negedge clk);
    chk("post_ack_ready", 32'(ex_ready), 32'd1);
    chk("post_ack_wb", 32'(wb_valid), 32'd0);

    issue(MOP_NONE, 3'b000, 32'h0000_0042, 0, 5'd1, 1,
          mkwb(32'h42, 1, 5'd1, 0, 1));
    wait_done();

    repeat (2) @(negedge clk);
    chk("wbq_empty", 32'(wbq.size()), 32'd0);
    chk("dmq_empty", 32'(dmq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst_n  in  1  synchronous active-low reset.
REQ-004 ex_valid  in  1  execute stage presents an op this cycle.
REQ-005 ex_ready  out  1  unit can accept an op; high only in IDLE.
REQ-006 ALU_result  in  32  ALU output: effective address for load/store, result for non-memory ops.
REQ-007 store_data  in  32  rs2 value for stores.
REQ-008 mem_op  in  2  00 none, 01 load, 10 store, 11 treated as none.
REQ-009 funct3  in  3  access size/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-010 rd_in  in  5  destination register.
REQ-011 dmem_req, dmem_we  out  1 each  memory request, write enable.
REQ-012 dmem_addr  out  32  word-aligned address (ALU_result[31:2], 2'b00).
REQ-013 dmem_wdata  out  32  store data replicated to lanes; dmem_be  out  4  byte enables.
REQ-014 dmem_ack  in  1  request completed; dmem_rdata  in  32  load word, valid with ack.
REQ-015 wb_valid  out  1  one-cycle writeback strobe; wb_data  out  32; wb_rd  out  5.
REQ-016 misalign_trap  out  1  one-cycle misaligned-access flag.

Function
REQ-017 States SHALL be IDLE, MEM, RESP.
REQ-018 Accept occurs on an edge where ex_valid && ex_ready; op, address, data, funct3, rd are registered.
REQ-019 Non-memory accept: IDLE->RESP; wb_valid high the following cycle with wb_data = registered ALU_result; latency 1.
REQ-020 Load/store accept: IDLE->MEM; dmem_req held high with stable addr/we/be/wdata every MEM cycle until dmem_ack is sampled high.
REQ-021 Ack in MEM: MEM->RESP; load data captured from dmem_rdata on that edge; a 0-wait-state memory gives latency 2.
REQ-022 RESP lasts exactly one cycle, then IDLE; wb_valid high only in RESP.
REQ-023 Load result: byte/half selected by addr[1:0]/addr[1], sign-extended for LB/LH, zero-extended for LBU/LHU.
REQ-024 Stores: be = 0001<<addr[1:0] (SB), 0011<<{addr[1],0} (SH), 1111 (SW); wdata = byte x4 / half x2 / word.
REQ-025 Stores and trapped ops SHALL drive wb_rd = 0 in RESP; all other ops drive the registered rd.
REQ-026 dmem_ack outside MEM SHALL be ignored; ex_valid outside IDLE SHALL be ignored.
REQ-027 Invalid funct3 (011, 110, 111) with mem_op load/store SHALL be treated as a word access.

Reset
REQ-028 rst_n low at an edge SHALL force IDLE and all outputs 0 on the next cycle, including mid-MEM; the outstanding request is abandoned and a later ack is ignored.
REQ-029 Outputs are registered or decoded from registered state only; no ex_* to dmem_* combinational path.

Configuration
REQ-030 Macro MISALIGN_TRAP_EN defined: a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL skip MEM (no dmem_req), go IDLE->RESP, and pulse misalign_trap with wb_valid.
REQ-031 MISALIGN_TRAP_EN undefined: misalign_trap SHALL be tied 0; misaligned accesses proceed, halves using lane addr[1], words using all lanes.

Structure
REQ-032 A shared package mem_pkg SHALL hold the mem_op codes, the funct3 size encodings and the state enum.
REQ-033 The combinational lane extract and extend logic SHALL live in a sub-module load_align.

Verification
REQ-034 ADD op, ALU_result=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=5, no dmem_req.
REQ-035 LB at 0x103, ack after 3 wait cycles, rdata=0x80FF_0000 -> dmem_req 4 cycles, addr=0x100, wb_data=0xFFFF_FF80.
REQ-036 SH at 0x202, data 0xABCD_1234, immediate ack -> be=1100, wdata=0x1234_1234, we=1, wb_rd=0.
REQ-037 LHU at 0x2, rdata=0x8001_0000 -> wb_data=0x0000_8001.
REQ-038 LW at 0x3: with macro -> misalign_trap=1, no dmem_req; without macro -> dmem_addr=0x0, normal load.
REQ-039 rst_n low during MEM, then ack -> IDLE, ex_ready=1, no wb_valid.
